// File: rtl/window3x3_gen.sv
// Streaming 3x3 sliding-window generator: raster pixels in, nine window taps out.
module window3x3_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data0,
    output logic [DATA_W-1:0] o_data1,
    output logic [DATA_W-1:0] o_data2,
    output logic [DATA_W-1:0] o_data3,
    output logic [DATA_W-1:0] o_data4,
    output logic [DATA_W-1:0] o_data5,
    output logic [DATA_W-1:0] o_data6,
    output logic [DATA_W-1:0] o_data7,
    output logic [DATA_W-1:0] o_data8,
    output logic              o_last
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned TAPS  = 9;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] lb0_q [IMG_W];   // row r-1
    logic [DATA_W-1:0] lb1_q [IMG_W];   // row r-2
    logic [DATA_W-1:0] win_q [TAPS];
    logic [DATA_W-1:0] win_d [TAPS];
    logic [DATA_W-1:0] out_q [TAPS];
    logic [DATA_W-1:0] out_d [TAPS];
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              acc;
    logic              at_last_col;
    logic              at_last_row;

    // Single output stage: a pending window only blocks input while downstream stalls.
    assign o_ready     = ~valid_q | i_ready;
    assign acc         = i_valid & o_ready;
    assign at_last_col = (col_q == COL_W'(IMG_W - 1));
    assign at_last_row = (row_q == ROW_W'(IMG_H - 1));

    // Next-state: counters, window shift, output stage load/drain.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        last_d  = last_q;
        for (int k = 0; k < int'(TAPS); k++) begin
            win_d[k] = win_q[k];
            out_d[k] = out_q[k];
        end

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (acc) begin
            for (int rr = 0; rr < 3; rr++) begin
                win_d[rr*3]     = win_q[rr*3 + 1];
                win_d[rr*3 + 1] = win_q[rr*3 + 2];
            end
            win_d[2] = lb1_q[col_q];
            win_d[5] = lb0_q[col_q];
            win_d[8] = i_data;

            if (at_last_col) begin
                col_d = '0;
                row_d = at_last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (row_q >= ROW_W'(2) && col_q >= COL_W'(2)) begin
                valid_d = 1'b1;
                last_d  = at_last_row & at_last_col;
                for (int k = 0; k < int'(TAPS); k++) begin
                    out_d[k] = win_d[k];
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int k = 0; k < int'(TAPS); k++) begin
                win_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            for (int k = 0; k < int'(TAPS); k++) begin
                win_q[k] <= win_d[k];
                out_q[k] <= out_d[k];
            end
        end
    end

    // Line buffers: plain RAM, no reset; each column shifts up one row per accept.
    always_ff @(posedge i_clk) begin
        if (acc) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= i_data;
        end
    end

    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_data0 = out_q[0];
    assign o_data1 = out_q[1];
    assign o_data2 = out_q[2];
    assign o_data3 = out_q[3];
    assign o_data4 = out_q[4];
    assign o_data5 = out_q[5];
    assign o_data6 = out_q[6];
    assign o_data7 = out_q[7];
    assign o_data8 = out_q[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen on a 4x4 frame.
`timescale 1ns/1ps
module tb_window3x3_gen;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data0, o_data1, o_data2, o_data3, o_data4;
    logic [7:0] o_data5, o_data6, o_data7, o_data8;
    logic       o_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [72:0] got_q[$];

    window3x3_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2),
        .o_data3(o_data3), .o_data4(o_data4), .o_data5(o_data5),
        .o_data6(o_data6), .o_data7(o_data7), .o_data8(o_data8),
        .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    // Record every transferred window as {last, d0..d8}.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready)
            got_q.push_back({o_last, o_data0, o_data1, o_data2, o_data3, o_data4,
                             o_data5, o_data6, o_data7, o_data8});
    end

    // Expected window centred-right at pixel (r,c) of a 4x4 frame with pixel = base + r*4 + c.
    function automatic logic [72:0] exp_win(input int base, input int r, input int c);
        logic [72:0] w;
        w = '0;
        w[72] = (r == 3 && c == 3);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[71 - 8*(i*3 + j) -: 8] = 8'(base + (r - 2 + i) * 4 + (c - 2 + j));
        return w;
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    // Present one pixel after 'gap' idle cycles; returns just after the accepting edge.
    task automatic send_pixel(input logic [7:0] d, input int gap);
        bit done;
        done = 0;
        i_valid = 1'b0;
        repeat (gap) begin
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b1;
        i_data  = d;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge i_clk);
            if (o_ready) done = 1;
            @(posedge i_clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout pixel=%0d not accepted within 100 cycles", d);
        end
        i_valid = 1'b0;
        i_data  = 8'hxx;
    endtask

    task automatic wait_drain();
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_valid = 1'b0; i_ready = 1'b1; i_data = '0;
        do_reset();
        @(negedge i_clk);
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_checks++;
        if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", o_last); end
        n_checks++;
        if ({o_data0, o_data4, o_data8} !== 24'h0) begin
            n_fail++; $display("FAIL reset_data got=%h exp=000000", {o_data0, o_data4, o_data8});
        end
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_basic();
        got_q.delete();
        i_ready = 1'b1;
        for (int p = 0; p < 16; p++) begin
            send_pixel(8'(p), 0);
            if (p == 9) begin
                n_checks++;
                if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", o_valid); end
            end
            if (p == 10) begin
                n_checks++;
                if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got=%b exp=1", o_valid); end
            end
        end
        wait_drain();
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin
                n_fail++;
                $display("FAIL basic_win%0d got=%h exp=%h", k, got_q[k], exp_win(0, 2 + k/2, 2 + k%2));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] held;
        got_q.delete();
        i_ready = 1'b0;
        for (int p = 0; p < 11; p++) send_pixel(8'(p), 0);
        held = {o_data0, o_data1, o_data2, o_data3, o_data4, o_data5, o_data6, o_data7, o_data8};
        n_checks++;
        if (o_valid !== 1'b1 || held !== exp_win(0, 2, 2)) begin
            n_fail++; $display("FAIL bp_pending got=%b/%h exp=1/%h", o_valid, held, exp_win(0, 2, 2));
        end
        i_valid = 1'b1;
        i_data  = 8'd11;
        for (int t = 0; t < 3; t++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_stall cyc%0d ready=%b valid=%b exp ready=0 valid=1", t, o_ready, o_valid);
            end
            n_checks++;
            if ({o_data0, o_data1, o_data2, o_data3, o_data4, o_data5, o_data6, o_data7, o_data8} !== held) begin
                n_fail++; $display("FAIL bp_hold cyc%0d data changed, exp=%h", t, held);
            end
            @(posedge i_clk);
            #1;
        end
        i_ready = 1'b1;
        for (int p = 11; p < 16; p++) send_pixel(8'(p), 0);
        wait_drain();
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin
                n_fail++;
                $display("FAIL bp_win%0d got=%h exp=%h", k, got_q[k], exp_win(0, 2 + k/2, 2 + k%2));
            end
        end
    endtask

    task automatic test_gaps();
        got_q.delete();
        i_ready = 1'b1;
        for (int p = 0; p < 16; p++) send_pixel(8'(p), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0);
        wait_drain();
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL gaps_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin
                n_fail++;
                $display("FAIL gaps_win%0d got=%h exp=%h", k, got_q[k], exp_win(0, 2 + k/2, 2 + k%2));
            end
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        i_ready = 1'b1;
        for (int p = 0; p < 16; p++) send_pixel(8'(p), 0);
        for (int p = 0; p < 16; p++) send_pixel(8'(100 + p), 0);
        wait_drain();
        n_checks++;
        if (got_q.size() != 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", got_q.size()); end
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_win((k < 4) ? 0 : 100, 2 + (k%4)/2, 2 + k%2)) begin
                n_fail++;
                $display("FAIL b2b_win%0d got=%h exp=%h", k, got_q[k],
                         exp_win((k < 4) ? 0 : 100, 2 + (k%4)/2, 2 + k%2));
            end
        end
    endtask

    task automatic test_mid_reset();
        got_q.delete();
        i_ready = 1'b1;
        for (int p = 0; p < 7; p++) send_pixel(8'(200 + p), 0);
        do_reset();
        for (int p = 0; p < 16; p++) begin
            send_pixel(8'(p), 0);
            if (p < 10) begin
                n_checks++;
                if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_early_valid pix%0d got=%b exp=0", p, o_valid); end
            end
        end
        wait_drain();
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL rst_count got=%0d exp=4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin
                n_fail++;
                $display("FAIL rst_win%0d got=%h exp=%h", k, got_q[k], exp_win(0, 2 + k/2, 2 + k%2));
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
